present_key_expander: RTL and testbench

Sequential PRESENT round-key generator covering both the 80-bit and the 128-bit key variants, selected by parameter. It loads a cipher key on a start strobe. It then streams the round keys K1..K_NUM_RK in order, one per accepted transfer, over a valid/ready handshake. It sits between the key register and the iterative PRESENT datapath, replacing a per-round combinational key update.

---
 rtl/present_key_expander.sv | 109 ++++++++++
 tb/tb_present_key_expander.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_key_expander.sv
// PRESENT round-key generator (80- or 128-bit key) that streams K1..K_NUM_RK
// over a valid/ready handshake, one key update per accepted transfer.
module present_key_expander #(
  parameter int unsigned KEY_W  = 80,
  parameter int unsigned NUM_RK = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [KEY_W-1:0] key,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [63:0]      rk,
  output logic [4:0]       rk_idx,
  output logic             done
);

  if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
    $error("present_key_expander: KEY_W must be 80 or 128");
  end
  if (NUM_RK < 1 || NUM_RK > 32) begin : g_bad_num_rk
    $error("present_key_expander: NUM_RK must be in 1..32");
  end

  // Position of the 5-bit round-counter injection in the key register.
  localparam int unsigned CtrLsb  = (KEY_W == 128) ? 62 : 15;
  localparam logic [4:0]  LastIdx = 5'(NUM_RK - 1);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e           state_q;
  logic [KEY_W-1:0] key_q;
  logic [4:0]       cnt_q;
  logic             done_q;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      4'hF: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                  input logic [4:0]       c);
    logic [KEY_W-1:0] r;
    r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    r[KEY_W-1 -: 4] = sbox(r[KEY_W-1 -: 4]);
    if (KEY_W == 128) begin
      r[KEY_W-5 -: 4] = sbox(r[KEY_W-5 -: 4]);
    end
    r[CtrLsb +: 5] = r[CtrLsb +: 5] ^ c;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            key_q   <= key;
            cnt_q   <= '0;
            state_q <= StEmit;
          end
        end
        StEmit: begin
          if (rk_ready) begin
            if (cnt_q == LastIdx) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else begin
              key_q <= key_update(key_q, cnt_q + 5'd1);
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
      endcase
    end
  end

  assign busy     = (state_q == StEmit);
  assign rk_valid = (state_q == StEmit);
  assign rk       = key_q[KEY_W-1 -: 64];
  assign rk_idx   = cnt_q;
  assign done     = done_q;

endmodule

// File: tb/tb_present_key_expander.sv
// Directed bench for present_key_expander: 80-bit, 128-bit and NUM_RK=1 instances,
// hand-computed vectors plus an independent bit-level key-schedule model.
module tb_present_key_expander;

  logic clk, rst;

  logic        req_a, ready_a, busy_a, valid_a, done_a;
  logic [79:0] key_a;
  logic [63:0] rk_a;
  logic [4:0]  idx_a;

  logic         req_b, ready_b, busy_b, valid_b, done_b;
  logic [127:0] key_b;
  logic [63:0]  rk_b;
  logic [4:0]   idx_b;

  logic        req_c, ready_c, busy_c, valid_c, done_c;
  logic [79:0] key_c;
  logic [63:0] rk_c;
  logic [4:0]  idx_c;

  present_key_expander #(.KEY_W(80), .NUM_RK(32)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .key(key_a), .busy(busy_a), .rk_valid(valid_a),
    .rk_ready(ready_a), .rk(rk_a), .rk_idx(idx_a), .done(done_a)
  );

  present_key_expander #(.KEY_W(128), .NUM_RK(32)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .key(key_b), .busy(busy_b), .rk_valid(valid_b),
    .rk_ready(ready_b), .rk(rk_b), .rk_idx(idx_b), .done(done_b)
  );

  present_key_expander #(.KEY_W(80), .NUM_RK(1)) dut_c (
    .clk(clk), .rst(rst), .req(req_c), .key(key_c), .busy(busy_c), .rk_valid(valid_c),
    .rk_ready(ready_c), .rk(rk_c), .rk_idx(idx_c), .done(done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Selected-instance view: 0 = 80-bit, 1 = 128-bit, 2 = NUM_RK=1.
  int          cur_sel = 0;
  logic        s_valid, s_busy, s_done;
  logic [63:0] s_rk;
  logic [4:0]  s_idx;

  always_comb begin
    s_valid = valid_a; s_busy = busy_a; s_done = done_a; s_rk = rk_a; s_idx = idx_a;
    case (cur_sel)
      1: begin s_valid = valid_b; s_busy = busy_b; s_done = done_b; s_rk = rk_b; s_idx = idx_b; end
      2: begin s_valid = valid_c; s_busy = busy_c; s_done = done_c; s_rk = rk_c; s_idx = idx_c; end
      default: ;
    endcase
  end

  logic [3:0]  sbox_t [16];
  logic [63:0] got_rk [32];
  int          got_n, busy_cnt, done_cnt, extra_valid;
  bit          order_ok;

  typedef struct {
    int           sel;
    logic [127:0] key;
    int           idx;
    logic [63:0]  exp_rk;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic r, input logic [127:0] k);
    case (sel)
      0: begin req_a = r; key_a = k[79:0]; end
      1: begin req_b = r; key_b = k; end
      default: begin req_c = r; key_c = k[79:0]; end
    endcase
  endtask

  task automatic set_ready(input int sel, input logic r);
    case (sel)
      0: ready_a = r;
      1: ready_b = r;
      default: ready_c = r;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit-by-bit rotation, table S-box: deliberately unlike the RTL's slice form.
  function automatic logic [127:0] model_next(input logic [127:0] k, input int w, input int c);
    logic [127:0] r;
    logic [4:0]   cc;
    int           lsb;
    r = '0;
    for (int i = 0; i < w; i++) r[(i + 61) % w] = k[i];
    r[w-1 -: 4] = sbox_t[r[w-1 -: 4]];
    if (w == 128) r[w-5 -: 4] = sbox_t[r[w-5 -: 4]];
    cc  = c[4:0];
    lsb = (w == 80) ? 15 : 62;
    for (int j = 0; j < 5; j++) r[lsb + j] = r[lsb + j] ^ cc[j];
    return r;
  endfunction

  // Runs one full sequence with rk_ready held high, recording every presented key.
  task automatic collect(input int sel, input logic [127:0] k, input bit hold_req);
    bit fin;
    int last;
    last = (sel == 2) ? 0 : 31;
    cur_sel = sel;
    got_n = 0; busy_cnt = 0; done_cnt = 0; extra_valid = 0; order_ok = 1'b1;
    for (int i = 0; i < 32; i++) got_rk[i] = '0;
    set_ready(sel, 1'b1);
    set_req(sel, 1'b1, k);
    tick();
    set_req(sel, hold_req, ~k);
    fin = 1'b0;
    for (int cyc = 0; cyc < 45 && !fin; cyc++) begin
      if (s_busy) busy_cnt++;
      if (s_done) begin
        done_cnt++;
        fin = 1'b1;
      end
      if (s_valid) begin
        if (s_idx != got_n[4:0]) order_ok = 1'b0;
        if (got_n < 32) got_rk[got_n] = s_rk;
        got_n++;
        if (hold_req && int'(s_idx) == last) set_req(sel, 1'b0, ~k);
      end
      tick();
    end
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL collect_timeout: got no done, expected done within 45 cycles");
    end
    for (int i = 0; i < 2; i++) begin
      if (s_done) done_cnt++;
      if (s_valid) extra_valid++;
      tick();
    end
  endtask

  task automatic verify_seq(input int sel, input logic [127:0] k, input int exp_n);
    logic [127:0] cur, tmp;
    int w;
    w   = (sel == 1) ? 128 : 80;
    cur = (w == 80) ? {48'h0, k[79:0]} : k;
    check("seq_count", got_n, exp_n);
    check("seq_idx_order", order_ok, 1);
    check("seq_done_pulses", done_cnt, 1);
    check("seq_busy_cycles", busy_cnt, exp_n);
    check("seq_valid_after_done", extra_valid, 0);
    for (int i = 0; i < exp_n; i++) begin
      tmp = cur >> (w - 64);
      check($sformatf("seq_rk[%0d]", i), got_rk[i], tmp[63:0]);
      cur = model_next(cur, w, i + 1);
    end
  endtask

  task automatic drain_to_done();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (s_done) seen = 1'b1;
      else tick();
    end
    check("drain_done_seen", seen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sbox_t = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    vecs[0] = '{0, 128'h0, 0, 64'h0000000000000000};
    vecs[1] = '{0, 128'h0, 1, 64'hC000000000000000};
    vecs[2] = '{0, 128'h0, 2, 64'h5000180000000001};
    vecs[3] = '{1, 128'h0, 0, 64'h0000000000000000};
    vecs[4] = '{1, 128'h0, 1, 64'hCC00000000000000};
    vecs[5] = '{1, 128'h0, 2, 64'hC300000000000000};
    vecs[6] = '{0, {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF}, 0, 64'hFFFFFFFFFFFFFFFF};
    vecs[7] = '{0, {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF}, 1, 64'h2FFFFFFFFFFFFFFF};

    rst = 1'b1;
    req_a = 0; key_a = '0; ready_a = 0;
    req_b = 0; key_b = '0; ready_b = 0;
    req_c = 0; key_c = '0; ready_c = 0;
    repeat (2) tick();
    cur_sel = 0;
    check("reset_busy", s_busy, 0);
    check("reset_valid", s_valid, 0);
    check("reset_rk", s_rk, 0);
    check("reset_idx", s_idx, 0);
    check("reset_done", s_done, 0);
    rst = 1'b0;
    tick();
    check("idle_valid_no_req", s_valid, 0);

    // Table-driven known-answer vectors, each on a fresh sequence.
    for (int v = 0; v < 8; v++) begin
      collect(vecs[v].sel, vecs[v].key, 1'b0);
      check($sformatf("vec%0d_rk", v), got_rk[vecs[v].idx], vecs[v].exp_rk);
      if (v == 0 || v == 3) verify_seq(vecs[v].sel, vecs[v].key, 32);
    end

    collect(0, {48'h0, 80'h0123456789ABCDEF4567}, 1'b0);
    verify_seq(0, {48'h0, 80'h0123456789ABCDEF4567}, 32);
    collect(1, 128'h0123456789ABCDEFFEDCBA9876543210, 1'b0);
    verify_seq(1, 128'h0123456789ABCDEFFEDCBA9876543210, 32);

    // Backpressure while idx 1 is presented.
    cur_sel = 0;
    set_ready(0, 1'b1);
    set_req(0, 1'b1, 128'h0);
    tick();
    set_req(0, 1'b0, 128'h0);
    tick();
    check("bp_idx_before", s_idx, 1);
    check("bp_rk_before", s_rk, 64'hC000000000000000);
    set_ready(0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_hold_idx%0d", i), s_idx, 1);
      check($sformatf("bp_hold_rk%0d", i), s_rk, 64'hC000000000000000);
      check($sformatf("bp_hold_valid%0d", i), s_valid, 1);
    end
    set_ready(0, 1'b1);
    tick();
    check("bp_resume_idx", s_idx, 2);
    check("bp_resume_rk", s_rk, 64'h5000180000000001);
    drain_to_done();
    tick();

    // Asynchronous reset in the middle of a sequence.
    set_req(0, 1'b1, 128'h0);
    tick();
    set_req(0, 1'b0, 128'h0);
    for (int c = 0; c < 10 && s_idx != 5'd5; c++) tick();
    check("mid_reset_reached_idx5", s_idx, 5);
    #2 rst = 1'b1;
    #1;
    check("mid_reset_valid", s_valid, 0);
    check("mid_reset_busy", s_busy, 0);
    check("mid_reset_rk", s_rk, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_reset_idle", s_valid, 0);
    collect(0, 128'h0, 1'b0);
    check("post_reset_k1", got_rk[0], 64'h0);
    check("post_reset_k2", got_rk[1], 64'hC000000000000000);

    // req held high for the whole sequence is ignored.
    collect(0, {48'h0, 80'h13579BDF02468ACE1357}, 1'b1);
    verify_seq(0, {48'h0, 80'h13579BDF02468ACE1357}, 32);

    // req on the done cycle starts a back-to-back sequence.
    cur_sel = 0;
    set_ready(0, 1'b1);
    set_req(0, 1'b1, 128'h0);
    tick();
    set_req(0, 1'b0, 128'h0);
    drain_to_done();
    set_req(0, 1'b1, {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF});
    tick();
    set_req(0, 1'b0, 128'h0);
    check("b2b_valid", s_valid, 1);
    check("b2b_busy", s_busy, 1);
    check("b2b_idx", s_idx, 0);
    check("b2b_rk", s_rk, 64'hFFFFFFFFFFFFFFFF);
    drain_to_done();
    tick();

    // NUM_RK=1: one transfer of K1, never updated.
    collect(2, {48'h0, 80'hDEADBEEFCAFEF00D1234}, 1'b0);
    verify_seq(2, {48'h0, 80'hDEADBEEFCAFEF00D1234}, 1);
    check("nrk1_k1", got_rk[0], 64'hDEADBEEFCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
